// File: rtl/instr_register_ctrl.sv
// Round-robin write sequencer and read drain for the instr_register file.
// The register file is managed as a DEPTH-entry circular instruction queue.
module instr_register_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int OPC_W   = 4,
    parameter int OPD_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OPC_W-1:0]   req_opcode,
    input  logic [NUM_REQ*OPD_W-1:0]   req_operand_a,
    input  logic [NUM_REQ*OPD_W-1:0]   req_operand_b,
    output logic                       load_en,
    output logic [OPC_W-1:0]           opcode,
    output logic [OPD_W-1:0]           operand_a,
    output logic [OPD_W-1:0]           operand_b,
    output logic [ADDR_W-1:0]          write_pointer,
    output logic [ADDR_W-1:0]          read_pointer,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [ADDR_W:0]            count,
    output logic                       full,
    output logic                       empty
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam int PW    = $clog2(NUM_REQ);

    logic [PW-1:0]    prio;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    idx;
    logic             xfer;
    logic             rd;
    logic [OPC_W-1:0] opc_arr [NUM_REQ];
    logic [OPD_W-1:0] opa_arr [NUM_REQ];
    logic [OPD_W-1:0] opb_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            opc_arr[i] = req_opcode[i*OPC_W +: OPC_W];
            opa_arr[i] = req_operand_a[i*OPD_W +: OPD_W];
            opb_arr[i] = req_operand_b[i*OPD_W +: OPD_W];
        end
    end

    // Full counts the write still in flight so a granted entry always has a slot.
    assign full        = (count + CW'(load_en)) == CW'(DEPTH);
    assign empty       = (count == '0);
    assign instr_valid = !empty;
    assign rd          = instr_valid & instr_ready;

    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        idx       = '0;
        xfer      = 1'b0;
        if (reset_n && !clear && !full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PW'((int'(prio) + k) % NUM_REQ);
                if (!xfer && req_valid[idx]) begin
                    xfer       = 1'b1;
                    gnt_idx    = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio          <= '0;
            load_en       <= 1'b0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else if (clear) begin
            prio          <= '0;
            load_en       <= 1'b0;
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else begin
            load_en <= xfer;
            if (xfer) begin
                opcode    <= opc_arr[gnt_idx];
                operand_a <= opa_arr[gnt_idx];
                operand_b <= opb_arr[gnt_idx];
                prio      <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            end
            if (load_en)
                write_pointer <= write_pointer + ADDR_W'(1);
            if (rd)
                read_pointer <= read_pointer + ADDR_W'(1);
            count <= count + CW'(load_en) - CW'(rd);
        end
    end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Bench for instr_register_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the instruction FIFO.
module tb_instr_register_ctrl;

    typedef logic [67:0] ent_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  req_opcode;
    logic [127:0] req_operand_a;
    logic [127:0] req_operand_b;
    logic         load_en;
    logic [3:0]   opcode;
    logic [31:0]  operand_a;
    logic [31:0]  operand_b;
    logic [4:0]   write_pointer;
    logic [4:0]   read_pointer;
    logic         instr_valid;
    logic         instr_ready;
    logic [5:0]   count;
    logic         full;
    logic         empty;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];
    ent_t mem[32];
    bit   m_pend;
    ent_t m_pend_e;
    int   m_wp, m_rp, m_prio;

    instr_register_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_operand_a(req_operand_a),
        .req_operand_b(req_operand_b), .load_en(load_en),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (!reset_n || clear || (q.size() + int'(m_pend)) == 32) return -1;
        for (int k = 0; k < 4; k++)
            if (req_valid[(m_prio + k) % 4]) return (m_prio + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int g);
        return (g < 0) ? 4'b0 : 4'(1 << g);
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 0;
        m_wp = 0;
        m_rp = 0;
        m_prio = 0;
    endtask

    task automatic rand_data();
        req_opcode    = 16'($urandom);
        req_operand_a = {$urandom, $urandom, $urandom, $urandom};
        req_operand_b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock edge; the model follows the FIFO rules, the array plays instr_register.
    task automatic tick();
        int g;
        bit rd;
        g  = exp_grant();
        rd = (q.size() > 0) && instr_ready;
        if (reset_n && !clear && load_en)
            mem[write_pointer] = {opcode, operand_a, operand_b};
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else begin
            if (rd) begin
                void'(q.pop_front());
                m_rp = (m_rp + 1) % 32;
            end
            if (m_pend) begin
                q.push_back(m_pend_e);
                m_wp = (m_wp + 1) % 32;
            end
            m_pend = (g >= 0);
            if (g >= 0) begin
                m_pend_e = {req_opcode[g*4 +: 4], req_operand_a[g*32 +: 32],
                            req_operand_b[g*32 +: 32]};
                m_prio = (g + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid   = 4'b0;
        instr_ready = 1'b0;
        clear       = 1'b0;
        reset_n     = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 1'b0;
        instr_ready = 1'b0;
        req_valid = 4'hF;
        rand_data();
        model_reset();
        #3;
        n_checks++;
        if ({req_ready, load_en, empty, full, count, write_pointer, read_pointer, instr_valid}
            !== {4'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5'd0, 5'd0, 1'b0})
            $display("FAIL reset_state: got rr=%b le=%b em=%b fu=%b cnt=%0d wp=%0d rp=%0d iv=%b want 0 0 1 0 0 0 0 0",
                     req_ready, load_en, empty, full, count, write_pointer, read_pointer, instr_valid);
        else n_pass++;
        n_checks++;
        if ({opcode, operand_a, operand_b} !== 68'd0)
            $display("FAIL reset_data: got %h want 0", {opcode, operand_a, operand_b});
        else n_pass++;
        req_valid = 4'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        do_reset();
        req_valid = 4'b0001;
        rand_data();
        req_opcode[3:0] = 4'd1;
        req_operand_a[31:0] = 32'd5;
        req_operand_b[31:0] = 32'd3;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready);
        else n_pass++;
        tick();
        req_valid = 4'b0;
        n_checks++;
        if ({load_en, write_pointer, opcode, operand_a, operand_b, count}
            !== {1'b1, 5'd0, 4'd1, 32'd5, 32'd3, 6'd0})
            $display("FAIL single_n1: got le=%b wp=%0d op=%0d a=%0d b=%0d cnt=%0d want 1 0 1 5 3 0",
                     load_en, write_pointer, opcode, operand_a, operand_b, count);
        else n_pass++;
        tick();
        n_checks++;
        if ({count, instr_valid, read_pointer, load_en} !== {6'd1, 1'b1, 5'd0, 1'b0})
            $display("FAIL single_n2: got cnt=%0d iv=%b rp=%0d le=%b want 1 1 0 0",
                     count, instr_valid, read_pointer, load_en);
        else n_pass++;
        n_checks++;
        if (mem[read_pointer] !== {4'd1, 32'd5, 32'd3})
            $display("FAIL single_entry: got %h want %h", mem[read_pointer], {4'd1, 32'd5, 32'd3});
        else n_pass++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if ({count, empty, read_pointer} !== {6'd0, 1'b1, 5'd1})
            $display("FAIL single_drain: got cnt=%0d em=%b rp=%0d want 0 1 1", count, empty, read_pointer);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int s_all[6] = '{0, 1, 2, 3, 0, 1};
        int s_alt[4] = '{1, 3, 1, 3};
        do_reset();
        req_valid = 4'hF;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            #1;
            n_checks++;
            if (req_ready !== onehot(s_all[i]))
                $display("FAIL rr_all_%0d: got %b want %b", i, req_ready, onehot(s_all[i]));
            else n_pass++;
            tick();
        end
        do_reset();
        req_valid = 4'b1010;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            #1;
            n_checks++;
            if (req_ready !== onehot(s_alt[i]))
                $display("FAIL rr_alt_%0d: got %b want %b", i, req_ready, onehot(s_alt[i]));
            else n_pass++;
            tick();
        end
        req_valid = 4'b0;
    endtask

    task automatic test_full_wrap();
        int hs = 0;
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 40 && (q.size() + int'(m_pend)) != 32; i++) begin
            rand_data();
            #1;
            n_checks++;
            if (req_ready !== onehot(exp_grant()))
                $display("FAIL fill_grant_%0d: got %b want %b", i, req_ready, onehot(exp_grant()));
            else n_pass++;
            if (req_ready[0]) hs++;
            tick();
        end
        tick();
        n_checks++;
        if ({count, full, req_ready, write_pointer} !== {6'd32, 1'b1, 4'b0, 5'd0} || hs != 32)
            $display("FAIL full_state: got cnt=%0d fu=%b rr=%b wp=%0d hs=%0d want 32 1 0000 0 32",
                     count, full, req_ready, write_pointer, hs);
        else n_pass++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if ({read_pointer, count, full, req_ready} !== {5'd1, 6'd31, 1'b0, 4'b0001})
            $display("FAIL full_read: got rp=%0d cnt=%0d fu=%b rr=%b want 1 31 0 0001",
                     read_pointer, count, full, req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({load_en, write_pointer, full} !== {1'b1, 5'd0, 1'b1} || {opcode, operand_a, operand_b} !== m_pend_e)
            $display("FAIL wrap_write: got le=%b wp=%0d fu=%b data=%h want 1 0 1 %h",
                     load_en, write_pointer, full, {opcode, operand_a, operand_b}, m_pend_e);
        else n_pass++;
        req_valid = 4'b0;
        tick();
        n_checks++;
        if ({count, full, write_pointer} !== {6'd32, 1'b1, 5'd1})
            $display("FAIL wrap_commit: got cnt=%0d fu=%b wp=%0d want 32 1 1", count, full, write_pointer);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            tick();
        end
        req_valid = 4'b0;
        tick();
        req_valid = 4'b0100;
        rand_data();
        tick();
        req_valid = 4'b0;
        n_checks++;
        if ({load_en, count, write_pointer, read_pointer} !== {1'b1, 6'd5, 5'd5, 5'd0})
            $display("FAIL simul_pre: got le=%b cnt=%0d wp=%0d rp=%0d want 1 5 5 0",
                     load_en, count, write_pointer, read_pointer);
        else n_pass++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if ({count, write_pointer, read_pointer} !== {6'd5, 5'd6, 5'd1})
            $display("FAIL simul_post: got cnt=%0d wp=%0d rp=%0d want 5 6 1",
                     count, write_pointer, read_pointer);
        else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        req_valid = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            rand_data();
            tick();
        end
        req_valid = 4'b0;
        tick();
        req_valid = 4'b0010;
        tick();
        clear = 1'b1;
        #1;
        n_checks++;
        if ({count, load_en, req_ready} !== {6'd7, 1'b1, 4'b0})
            $display("FAIL clear_pre: got cnt=%0d le=%b rr=%b want 7 1 0000", count, load_en, req_ready);
        else n_pass++;
        tick();
        clear = 1'b0;
        req_valid = 4'b0;
        n_checks++;
        if ({count, empty, load_en, write_pointer, read_pointer} !== {6'd0, 1'b1, 1'b0, 5'd0, 5'd0})
            $display("FAIL clear_post: got cnt=%0d em=%b le=%b wp=%0d rp=%0d want 0 1 0 0 0",
                     count, empty, load_en, write_pointer, read_pointer);
        else n_pass++;
        tick();
        n_checks++;
        if ({count, empty, instr_valid} !== {6'd0, 1'b1, 1'b0})
            $display("FAIL clear_nocommit: got cnt=%0d em=%b iv=%b want 0 1 0", count, empty, instr_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, load_en, empty, count, write_pointer, read_pointer, opcode}
            !== {4'b0, 1'b0, 1'b1, 6'd0, 5'd0, 5'd0, 4'd0})
            $display("FAIL async_reset: got rr=%b le=%b em=%b cnt=%0d wp=%0d rp=%0d op=%0d want 0 0 1 0 0 0 0",
                     req_ready, load_en, empty, count, write_pointer, read_pointer, opcode);
        else n_pass++;
        model_reset();
        req_valid = 4'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({count, load_en} !== {6'd0, 1'b0})
            $display("FAIL reset_drop: got cnt=%0d le=%b want 0 0", count, load_en);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_valid = 4'($urandom);
            instr_ready = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 60) == 0);
            rand_data();
            #1;
            n_checks++;
            if (req_ready !== onehot(exp_grant())) begin
                if (bad++ < 10) $display("FAIL rand_grant_%0d: got %b want %b", i, req_ready, onehot(exp_grant()));
            end else n_pass++;
            tick();
            clear = 1'b0;
            n_checks++;
            if ({count, load_en, write_pointer, read_pointer, instr_valid, empty, full}
                !== {6'(q.size()), m_pend, 5'(m_wp), 5'(m_rp), q.size() > 0, q.size() == 0,
                     (q.size() + int'(m_pend)) == 32}) begin
                if (bad++ < 10)
                    $display("FAIL rand_state_%0d: got cnt=%0d le=%b wp=%0d rp=%0d fu=%b want %0d %b %0d %0d %b",
                             i, count, load_en, write_pointer, read_pointer, full, q.size(), m_pend,
                             m_wp, m_rp, (q.size() + int'(m_pend)) == 32);
            end else n_pass++;
            if (m_pend) begin
                n_checks++;
                if ({opcode, operand_a, operand_b} !== m_pend_e) begin
                    if (bad++ < 10) $display("FAIL rand_wdata_%0d: got %h want %h", i, {opcode, operand_a, operand_b}, m_pend_e);
                end else n_pass++;
            end
            if (q.size() > 0) begin
                n_checks++;
                if (mem[read_pointer] !== q[0]) begin
                    if (bad++ < 10) $display("FAIL rand_head_%0d: got %h want %h", i, mem[read_pointer], q[0]);
                end else n_pass++;
            end
        end
        req_valid = 4'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_full_wrap();
        test_simultaneous();
        test_clear();
        test_reset_midburst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
